// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decoder behind valid/ready handshakes with flush and delivered-instruction counter
module decode_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [XLEN-1:0]  imm,
  output logic [3:0]       alu_op,
  output logic             src2_imm,
  output logic             is_word,
  output logic             reg_wen,
  output logic             mem_ren,
  output logic             mem_wen,
  output logic [7:0]       mem_wmask,
  output logic             mem_unsigned,
  output logic             is_branch,
  output logic [2:0]       br_cond,
  output logic             is_jal,
  output logic             is_jalr,
  output logic             is_lui,
  output logic             is_auipc,
  output logic             is_ebreak,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_count
);
  localparam bit RV64 = XLEN == 64;
  localparam logic [31:0] F3_ALU = {4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd0};
  logic [6:0] w_op, w_f7;
  logic [2:0] w_f3;
  logic w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st, w_opi, w_opr, w_opiw, w_oprw, w_ebreak;
  logic w_f7ok, w_shok, w_shwok, w_legal, w_alt, w_wen, w_src2;
  logic [3:0] w_alu;
  logic [7:0] w_mask;
  logic [XLEN-1:0] w_imm;
  assign w_op     = in_inst[6:0];
  assign w_f3     = in_inst[14:12];
  assign w_f7     = in_inst[31:25];
  assign w_lui    = w_op == 7'h37;
  assign w_auipc  = w_op == 7'h17;
  assign w_jal    = w_op == 7'h6f;
  assign w_jalr   = w_op == 7'h67;
  assign w_br     = w_op == 7'h63;
  assign w_ld     = w_op == 7'h03;
  assign w_st     = w_op == 7'h23;
  assign w_opi    = w_op == 7'h13;
  assign w_opr    = w_op == 7'h33;
  assign w_opiw   = w_op == 7'h1b;
  assign w_oprw   = w_op == 7'h3b;
  assign w_ebreak = in_inst == 32'h0010_0073;
  assign w_f7ok   = w_f7 == 7'd0 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5));
  assign w_shwok  = w_f3 == 3'd1 ? w_f7 == 7'd0 : (w_f7 == 7'd0 || w_f7 == 7'h20);
  assign w_shok   = !RV64 ? w_shwok :
                    w_f3 == 3'd1 ? in_inst[31:26] == 6'd0 :
                    (in_inst[31:26] == 6'd0 || in_inst[31:26] == 6'b010000);
  assign w_legal  = in_inst[1:0] == 2'b11 && (w_lui || w_auipc || w_jal || w_ebreak ||
                    (w_jalr && w_f3 == 3'd0) ||
                    (w_br && w_f3[2:1] != 2'b01) ||
                    (w_ld && w_f3 != 3'd7 && (RV64 || (w_f3 != 3'd3 && w_f3 != 3'd6))) ||
                    (w_st && !w_f3[2] && (RV64 || w_f3 != 3'd3)) ||
                    (w_opi && ((w_f3 == 3'd1 || w_f3 == 3'd5) ? w_shok : 1'b1)) ||
                    (w_opr && w_f7ok) ||
                    (RV64 && w_opiw && (w_f3 == 3'd0 || ((w_f3 == 3'd1 || w_f3 == 3'd5) && w_shwok))) ||
                    (RV64 && w_oprw && (w_f3 == 3'd0 || w_f3 == 3'd1 || w_f3 == 3'd5) && w_f7ok));
  assign w_alt    = ((w_opr || w_oprw) && in_inst[30]) || ((w_opi || w_opiw) && w_f3 == 3'd5 && in_inst[30]);
  assign w_alu    = !w_legal ? 4'd0 :
                    w_br ? (!w_f3[2] ? 4'd1 : w_f3[1] ? 4'd4 : 4'd3) :
                    (w_opr || w_oprw || w_opi || w_opiw) ? (w_alt ? (w_f3 == 3'd0 ? 4'd1 : 4'd7) : F3_ALU[{w_f3, 2'b00} +: 4]) :
                    4'd0;
  assign w_imm    = (!w_legal || w_opr || w_oprw) ? '0 :
                    (w_lui || w_auipc) ? XLEN'($signed({in_inst[31:12], 12'h000})) :
                    w_jal ? XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0})) :
                    w_br ? XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0})) :
                    w_st ? XLEN'($signed({in_inst[31:25], in_inst[11:7]})) :
                    XLEN'($signed(in_inst[31:20]));
  assign w_mask   = (w_legal && w_st) ? (w_f3[1] ? (w_f3[0] ? 8'hFF : 8'h0F) : (w_f3[0] ? 8'h03 : 8'h01)) : 8'h00;
  assign w_wen    = w_legal && (w_opi || w_opiw || w_opr || w_oprw || w_lui || w_auipc || w_jal || w_jalr || w_ld);
  assign w_src2   = w_legal && (w_opi || w_opiw || w_lui || w_auipc || w_jal || w_jalr || w_ld || w_st);
  assign in_ready = !out_valid || out_ready || flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      rd           <= '0;
      rs1          <= '0;
      rs2          <= '0;
      imm          <= '0;
      alu_op       <= '0;
      src2_imm     <= 1'b0;
      is_word      <= 1'b0;
      reg_wen      <= 1'b0;
      mem_ren      <= 1'b0;
      mem_wen      <= 1'b0;
      mem_wmask    <= '0;
      mem_unsigned <= 1'b0;
      is_branch    <= 1'b0;
      br_cond      <= '0;
      is_jal       <= 1'b0;
      is_jalr      <= 1'b0;
      is_lui       <= 1'b0;
      is_auipc     <= 1'b0;
      is_ebreak    <= 1'b0;
      illegal      <= 1'b0;
      dec_count    <= '0;
    end else begin
      if (out_valid && out_ready && !flush) dec_count <= dec_count + CNT_W'(1);
      if (flush) out_valid <= 1'b0;
      else if (in_ready) begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_pc       <= in_pc;
          rd           <= w_wen ? in_inst[11:7] : 5'd0;
          rs1          <= in_inst[19:15];
          rs2          <= in_inst[24:20];
          imm          <= w_imm;
          alu_op       <= w_alu;
          src2_imm     <= w_src2;
          is_word      <= w_legal && (w_opiw || w_oprw);
          reg_wen      <= w_wen;
          mem_ren      <= w_legal && w_ld;
          mem_wen      <= w_legal && w_st;
          mem_wmask    <= w_mask;
          mem_unsigned <= w_legal && w_ld && w_f3[2];
          is_branch    <= w_legal && w_br;
          br_cond      <= (w_legal && w_br) ? w_f3 : 3'd0;
          is_jal       <= w_legal && w_jal;
          is_jalr      <= w_legal && w_jalr;
          is_lui       <= w_legal && w_lui;
          is_auipc     <= w_legal && w_auipc;
          is_ebreak    <= w_ebreak;
          illegal      <= !w_legal;
        end
      end
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: model-based checking of decode_stage at XLEN=64 and XLEN=32 with directed vectors
module tb_decode_stage;
  typedef struct packed {
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        src2, word, wen, ren, mwen;
    logic [7:0]  mask;
    logic        uns, br;
    logic [2:0]  cond;
    logic        jal, jalr, lui, auipc, ebreak, ill;
  } dec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic flush = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, src2_imm, is_word, reg_wen, mem_ren, mem_wen, mem_unsigned, is_branch;
  logic is_jal, is_jalr, is_lui, is_auipc, is_ebreak, illegal;
  logic [63:0] out_pc, imm;
  logic [4:0] rd, rs1, rs2;
  logic [3:0] alu_op;
  logic [7:0] mem_wmask;
  logic [2:0] br_cond;
  logic [31:0] dec_count;
  logic q_in_ready, q_out_valid, q_src2_imm, q_is_word, q_reg_wen, q_mem_ren, q_mem_wen, q_mem_unsigned, q_is_branch;
  logic q_is_jal, q_is_jalr, q_is_lui, q_is_auipc, q_is_ebreak, q_illegal;
  logic [31:0] q_out_pc, q_imm;
  logic [4:0] q_rd, q_rs1, q_rs2;
  logic [3:0] q_alu_op;
  logic [7:0] q_mem_wmask;
  logic [2:0] q_br_cond;
  logic [31:0] q_dec_count;
  int errors = 0;
  int checks = 0;
  logic m_valid = 1'b0;
  logic m_zero = 1'b1;
  logic [31:0] m_inst = '0;
  logic [63:0] m_pc = '0;
  logic [31:0] m_cnt = '0;
  logic [63:0] pc = 64'hFFFF_FFFF_8000_0000;
  logic [63:0] hpc;
  int k, cyc;
  logic [31:0] vec [30] = '{
    32'h402081b3, 32'h4020d1b3, 32'h4030d093, 32'h02009093, 32'h8030d093, 32'h123452b7,
    32'hfffff317, 32'hff9ff0ef, 32'h00008067, 32'hfff14383, 32'h00215383, 32'h00416383,
    32'h00813383, 32'h00017383, 32'h007100a3, 32'h00711123, 32'h00712223, 32'h0020c463,
    32'h0020f463, 32'h0020a463, 32'h402081bb, 32'h4020d1bb, 32'h4010d09b, 32'h0210909b,
    32'hfff0c093, 32'h0ff0f093, 32'h0020e1b3, 32'h0020b1b3, 32'h8000a093, 32'h00000001};
  always #5 clk = ~clk;
  decode_stage #(.XLEN(64), .CNT_W(32)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm(imm), .alu_op(alu_op), .src2_imm(src2_imm), .is_word(is_word), .reg_wen(reg_wen),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_unsigned(mem_unsigned),
    .is_branch(is_branch), .br_cond(br_cond), .is_jal(is_jal), .is_jalr(is_jalr), .is_lui(is_lui),
    .is_auipc(is_auipc), .is_ebreak(is_ebreak), .illegal(illegal), .dec_count(dec_count));
  decode_stage #(.XLEN(32), .CNT_W(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(q_in_ready), .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .flush(flush), .out_valid(q_out_valid), .out_ready(out_ready), .out_pc(q_out_pc), .rd(q_rd), .rs1(q_rs1),
    .rs2(q_rs2), .imm(q_imm), .alu_op(q_alu_op), .src2_imm(q_src2_imm), .is_word(q_is_word), .reg_wen(q_reg_wen),
    .mem_ren(q_mem_ren), .mem_wen(q_mem_wen), .mem_wmask(q_mem_wmask), .mem_unsigned(q_mem_unsigned),
    .is_branch(q_is_branch), .br_cond(q_br_cond), .is_jal(q_is_jal), .is_jalr(q_is_jalr), .is_lui(q_is_lui),
    .is_auipc(q_is_auipc), .is_ebreak(q_is_ebreak), .illegal(q_illegal), .dec_count(q_dec_count));
  function automatic dec_t model(input logic [31:0] x, input bit rv64);
    dec_t d;
    logic [2:0] f3;
    logic [6:0] f7, hi;
    logic [3:0] alu_of [8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    bit ok, w;
    longint ii, si, bi, ui, ji;
    d = '0;
    f3 = x[14:12];
    f7 = x[31:25];
    ok = 1'b0;
    ii = $signed(x[31:20]);
    si = $signed({x[31:25], x[11:7]});
    bi = $signed({x[31], x[7], x[30:25], x[11:8], 1'b0});
    ui = $signed({x[31:12], 12'h000});
    ji = $signed({x[31], x[19:12], x[20], x[30:21], 1'b0});
    case (x[6:0])
      7'h37: begin ok = 1; d.lui = 1; d.wen = 1; d.src2 = 1; d.imm = ui; end
      7'h17: begin ok = 1; d.auipc = 1; d.wen = 1; d.src2 = 1; d.imm = ui; end
      7'h6f: begin ok = 1; d.jal = 1; d.wen = 1; d.src2 = 1; d.imm = ji; end
      7'h67: begin ok = f3 == 0; d.jalr = 1; d.wen = 1; d.src2 = 1; d.imm = ii; end
      7'h63: begin
        ok = f3 != 2 && f3 != 3; d.br = 1; d.cond = f3; d.imm = bi;
        d.alu = f3 < 2 ? 4'd1 : f3 < 6 ? 4'd3 : 4'd4;
      end
      7'h03: begin
        ok = f3 != 7 && (rv64 || (f3 != 3 && f3 != 6));
        d.ren = 1; d.wen = 1; d.src2 = 1; d.uns = f3 >= 4; d.imm = ii;
      end
      7'h23: begin
        ok = f3 < 3 || (f3 == 3 && rv64);
        d.mwen = 1; d.src2 = 1; d.mask = 8'((1 << (1 << f3)) - 1); d.imm = si;
      end
      7'h13, 7'h1b: begin
        w = x[3];
        hi = (w || !rv64) ? f7 : {x[31:26], 1'b0};
        ok = (!w || (rv64 && (f3 == 0 || f3 == 1 || f3 == 5))) &&
             (f3 == 1 ? hi == 0 : f3 == 5 ? (hi == 0 || hi == 7'h20) : 1'b1);
        d.wen = 1; d.src2 = 1; d.word = w; d.imm = ii;
        d.alu = (f3 == 5 && x[30]) ? 4'd7 : alu_of[f3];
      end
      7'h33, 7'h3b: begin
        w = x[3];
        ok = (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) && (!w || (rv64 && (f3 == 0 || f3 == 1 || f3 == 5)));
        d.wen = 1; d.word = w;
        d.alu = f7 == 7'h20 ? (f3 == 0 ? 4'd1 : 4'd7) : alu_of[f3];
      end
      7'h73: begin ok = x == 32'h00100073; d.ebreak = 1; d.imm = ii; end
      default: ok = 0;
    endcase
    if (!ok) begin
      d = '0;
      d.ill = 1;
    end
    d.rd = d.wen ? x[11:7] : 5'd0;
    return d;
  endfunction
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic step(input logic v, input logic [31:0] x, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid = v;
    in_inst = x;
    in_pc = pc;
    out_ready = ordy;
    flush = fl;
    pc = pc + 64'd4;
  endtask
  task automatic send(input logic [31:0] x);
    step(1'b1, x, 1'b1, 1'b0);
  endtask
  task automatic idle();
    step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_cnt = '0;
      m_zero = 1'b1;
    end else begin
      if (m_valid && out_ready && !flush) m_cnt = m_cnt + 32'd1;
      if (flush) m_valid = 1'b0;
      else if (!m_valid || out_ready) begin
        m_valid = in_valid;
        if (in_valid) begin
          m_inst = in_inst;
          m_pc = in_pc;
          m_zero = 1'b0;
        end
      end
    end
  end
  initial begin
    dec_t e, e32, a64, a32;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("out_valid", out_valid, m_valid);
      chk("out_valid32", q_out_valid, m_valid);
      chk("dec_count", dec_count, m_cnt);
      chk("dec_count32", q_dec_count, m_cnt);
      chk("in_ready", in_ready, !m_valid || out_ready || flush);
      chk("in_ready32", q_in_ready, !m_valid || out_ready || flush);
      if (m_valid || m_zero) begin
        e = m_valid ? model(m_inst, 1'b1) : '0;
        e32 = m_valid ? model(m_inst, 1'b0) : '0;
        e32.imm[63:32] = '0;
        a64 = {imm, rd, alu_op, src2_imm, is_word, reg_wen, mem_ren, mem_wen, mem_wmask, mem_unsigned,
               is_branch, br_cond, is_jal, is_jalr, is_lui, is_auipc, is_ebreak, illegal};
        a32 = {32'h0, q_imm, q_rd, q_alu_op, q_src2_imm, q_is_word, q_reg_wen, q_mem_ren, q_mem_wen, q_mem_wmask,
               q_mem_unsigned, q_is_branch, q_br_cond, q_is_jal, q_is_jalr, q_is_lui, q_is_auipc, q_is_ebreak, q_illegal};
        chk("decode64", a64, e);
        chk("decode32", a32, e32);
        chk("out_pc", out_pc, m_valid ? m_pc : 64'h0);
        chk("out_pc32", q_out_pc, m_valid ? m_pc[31:0] : 32'h0);
        chk("rs", {rs1, rs2}, m_valid ? {m_inst[19:15], m_inst[24:20]} : 10'h0);
        chk("rs32", {q_rs1, q_rs2}, m_valid ? {m_inst[19:15], m_inst[24:20]} : 10'h0);
      end
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", dec_count, 32'd0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_fields", {imm, reg_wen, illegal, alu_op}, 70'h0);
    send(32'h00500093);
    idle();
    @(negedge clk);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_rd_rs1", {rd, rs1}, {5'd1, 5'd0});
    chk("addi_imm", imm, 64'd5);
    chk("addi_ctl", {alu_op, src2_imm, reg_wen}, {4'd0, 1'b1, 1'b1});
    send(32'h0020b423);
    idle();
    @(negedge clk);
    chk("sd_store", {mem_wen, mem_wmask}, {1'b1, 8'hFF});
    chk("sd_imm", imm, 64'd8);
    chk("sd_nowrite", {reg_wen, rd}, 6'd0);
    chk("sd_rv32", {q_illegal, q_mem_wen}, 2'b10);
    send(32'hfe208ee3);
    idle();
    @(negedge clk);
    chk("beq_ctl", {is_branch, br_cond, alu_op}, {1'b1, 3'd0, 4'd1});
    chk("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
    send(32'h0010809b);
    idle();
    @(negedge clk);
    chk("addiw_word", is_word, 1'b1);
    chk("addiw_rv32", q_illegal, 1'b1);
    chk("count3", dec_count, 32'd3);
    send(32'h00100113);
    hpc = pc - 64'd4;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h00200193, 1'b0, 1'b0);
      @(negedge clk);
      chk("bp_ready", in_ready, 1'b0);
      chk("bp_count", dec_count, 32'd4);
      chk("bp_hold", {out_valid, out_pc, rd}, {1'b1, hpc, 5'd2});
    end
    step(1'b1, 32'h00200193, 1'b1, 1'b0);
    send(32'h00300213);
    send(32'h00400293);
    idle();
    idle();
    @(negedge clk);
    chk("stream_count", dec_count, 32'd8);
    send(32'h00500313);
    step(1'b1, 32'h00600393, 1'b0, 1'b1);
    @(negedge clk);
    chk("flush_ready", in_ready, 1'b1);
    hpc = pc;
    step(1'b1, 32'h00500093, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_count", dec_count, 32'd8);
    idle();
    @(negedge clk);
    chk("after_flush", {out_valid, out_pc, rd, imm}, {1'b1, hpc, 5'd1, 64'd5});
    chk("after_flush_count", dec_count, 32'd8);
    send(32'h00000000);
    idle();
    @(negedge clk);
    chk("zero_illegal", {illegal, reg_wen}, 2'b10);
    send(32'h00000073);
    idle();
    @(negedge clk);
    chk("ecall_illegal", {illegal, reg_wen, is_ebreak}, 3'b100);
    send(32'h021080b3);
    idle();
    @(negedge clk);
    chk("mul_illegal", {illegal, reg_wen, rd}, {1'b1, 1'b0, 5'd0});
    send(32'h00100073);
    idle();
    @(negedge clk);
    chk("ebreak", {is_ebreak, illegal}, 2'b10);
    k = 0;
    cyc = 0;
    while (k < 30 && cyc < 400) begin
      step(1'b1, vec[k], (cyc % 4) != 3, 1'b0);
      if (!m_valid || out_ready) k++;
      cyc++;
    end
    chk("stream_done", k, 30);
    idle();
    idle();
    send(32'h00500093);
    step(1'b1, 32'h402081b3, 1'b0, 1'b0);
    step(1'b1, 32'h402081b3, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_count", dec_count, 32'd0);
    chk("midrst_fields", {imm, reg_wen, alu_op, rd}, 74'h0);
    send(32'h00100073);
    idle();
    idle();
    @(negedge clk);
    chk("final_count", dec_count, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
